// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: loader/control inputs and issue/status outputs of instr_sequencer
interface instr_sequencer_if #(parameter int AW = 4);
  logic [3:0]    tick;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [8:0]    wr_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          step;
  logic          halt;
  logic          loop_en;
  logic [8:0]    din;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;
  logic [15:0]   instr_count;
  logic          wr_err;
  modport master (
    output tick, wr_en, wr_addr, wr_data, prog_len, start, step, halt, loop_en,
    input  din, busy, done, pc, instr_count, wr_err
  );
  modport slave (
    input  tick, wr_en, wr_addr, wr_data, prog_len, start, step, halt, loop_en,
    output din, busy, done, pc, instr_count, wr_err
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: program buffer and issue controller presenting one instruction per T1 to simple_proc
module instr_sequencer #(
  parameter int         DEPTH     = 16,
  parameter int         AW        = 4,
  parameter logic [8:0] NOP_INSTR = 9'b010000000
) (
  input logic              clk,
  input logic              rst_n,
  instr_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, DONE} state_t;
  localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);
  state_t        state_q, state_d;
  logic [8:0]    mem [DEPTH];
  logic [8:0]    din_q;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   cnt_q;
  logic [AW:0]   len;
  logic          done_q, done_d, wr_err_q, halt_pend_q, halt_pend_d, fin_q, fin_d, arm_q;
  logic          busy, issuing, last, launch, stop;
  assign len = (bus.prog_len > MAX_LEN) ? MAX_LEN : bus.prog_len;
  assign busy = state_q inside {RUN, STEP, DRAIN};
  // arm_q holds off issue until din has had a cycle to load mem[pc]
  assign issuing = (state_q == RUN || state_q == STEP) && arm_q && bus.tick == 4'b0001;
  assign last = ({1'b0, pc_q} + (AW+1)'(1)) >= len;
  assign launch = (state_q == IDLE || state_q == DONE) && !bus.halt && (bus.start || bus.step);
  assign stop = bus.halt || halt_pend_q;
  always_comb begin
    state_d = state_q;
    pc_d = issuing ? (last ? '0 : pc_q + AW'(1)) : pc_q;
    halt_pend_d = halt_pend_q;
    fin_d = fin_q;
    case (state_q)
      IDLE, DONE: if (launch) begin
        state_d = (len == '0) ? DONE : bus.start ? RUN : STEP;
        pc_d = (state_q == DONE) ? '0 : pc_q;
        halt_pend_d = 1'b0;
        fin_d = 1'b0;
      end
      RUN: if (issuing) begin
        state_d = (stop || (last && !bus.loop_en)) ? DRAIN : RUN;
        fin_d = !stop && last && !bus.loop_en;
      end else if (bus.halt) halt_pend_d = 1'b1;
      STEP: if (issuing) begin
        state_d = DRAIN;
        fin_d = last && !bus.loop_en;
      end
      DRAIN: if (bus.tick == 4'b1000) begin
        state_d = fin_q ? DONE : IDLE;
        halt_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    done_d = state_d == DONE && (state_q != DONE || launch);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      din_q       <= NOP_INSTR;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      fin_q       <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      din_q       <= (state_q == RUN || state_q == STEP) ? mem[pc_q] : NOP_INSTR;
      cnt_q       <= cnt_q + 16'(issuing);
      done_q      <= done_d;
      wr_err_q    <= bus.wr_en && busy;
      halt_pend_q <= halt_pend_d;
      fin_q       <= fin_d;
      arm_q       <= state_q == RUN || state_q == STEP;
    end
  always_ff @(posedge clk)
    if (bus.wr_en && !busy) mem[bus.wr_addr] <= bus.wr_data;
  assign bus.din         = din_q;
  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.pc          = pc_q;
  assign bus.instr_count = cnt_q;
  assign bus.wr_err      = wr_err_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench; stimulus queues expected issues, a monitor checks each issue
module tb_instr_sequencer;
  localparam logic [8:0] NOP = 9'b010000000;
  typedef struct packed {
    logic [8:0] instr;
    logic [3:0] pc;
  } exp_t;
  logic        clk;
  logic        rst_n;
  exp_t        q[$];
  logic [8:0]  mem_m [16];
  logic [15:0] exp_cnt;
  int          errors;
  int          checks;
  int          done_cnt;
  instr_sequencer_if #(.AW(4)) bus ();
  instr_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    bus.tick = 4'b0001;
    forever begin
      @(posedge clk);
      #1 bus.tick = {bus.tick[2:0], bus.tick[3]};
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    logic [8:0]  din_p;
    logic [3:0]  tick_p;
    logic [15:0] cnt_p;
    exp_t        e;
    din_p = NOP;
    tick_p = 4'b0;
    cnt_p = 16'd0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) done_cnt++;
      if (rst_n && bus.instr_count != cnt_p) begin
        check("count_step", bus.instr_count, cnt_p + 16'd1);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got din %0h with empty scoreboard", din_p);
        end else begin
          e = q.pop_front();
          check("issue_din", din_p, e.instr);
          check("issue_pc", bus.pc, e.pc);
          check("issue_tick", tick_p, 4'b0001);
        end
      end
      din_p = bus.din;
      tick_p = bus.tick;
      cnt_p = bus.instr_count;
    end
  end
  task automatic pulse(input bit s);
    @(posedge clk);
    #1;
    if (s) bus.start = 1'b1;
    else bus.step = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.step = 1'b0;
  endtask
  task automatic write(input int a, input logic [8:0] d, input logic exp_err);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'(a);
    bus.wr_data = d;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    @(negedge clk);
    check("wr_err", bus.wr_err, exp_err);
    if (!exp_err) mem_m[a] = d;
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(nm, n < 200, 1'b1);
  endtask
  task automatic run_prog(input int plen);
    int l = plen > 16 ? 16 : plen;
    int b = done_cnt;
    int n = 0;
    bus.prog_len = 5'(plen);
    for (int a = 0; a < l; a++) q.push_back(exp_t'{mem_m[a], 4'((a == l - 1) ? 0 : a + 1)});
    exp_cnt += 16'(l);
    pulse(1'b1);
    while (!bus.done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", n < 400, 1'b1);
    check("done_after_t4", bus.tick, 4'b0001);
    @(negedge clk);
    check("done_width", bus.done, 1'b0);
    check("done_once", done_cnt, b + 1);
    check("run_pc", bus.pc, 0);
    check("run_count", bus.instr_count, exp_cnt);
    check("run_busy", bus.busy, 1'b0);
    check("run_din", bus.din, NOP);
    check("run_sb_empty", q.size(), 0);
  endtask
  initial begin
    int b;
    int n;
    errors = 0;
    checks = 0;
    done_cnt = 0;
    exp_cnt = 16'd0;
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.prog_len = '0;
    bus.start = 1'b0;
    bus.step = 1'b0;
    bus.halt = 1'b0;
    bus.loop_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_din", bus.din, NOP);
    check("rst_pc", bus.pc, 0);
    check("rst_count", bus.instr_count, 0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_wr_err", bus.wr_err, 1'b0);
    write(0, 9'b000_001_011, 1'b0);
    write(1, 9'b010_001_010, 1'b0);
    write(2, 9'b011_001_001, 1'b0);
    for (int a = 3; a < 16; a++) write(a, 9'($urandom), 1'b0);
    run_prog(3);
    bus.prog_len = 5'd3;
    for (int k = 0; k < 3; k++) begin
      q.push_back(exp_t'{mem_m[k], 4'((k + 1) % 3)});
      exp_cnt++;
      pulse(1'b0);
      wait_idle("step_wait");
      check("step_pc", bus.pc, (k + 1) % 3);
      check("step_done", bus.done, k == 2);
      check("step_count", bus.instr_count, exp_cnt);
    end
    b = done_cnt;
    bus.prog_len = 5'd0;
    pulse(1'b1);
    @(negedge clk);
    check("len0_done", bus.done, 1'b1);
    check("len0_busy", bus.busy, 1'b0);
    check("len0_din", bus.din, NOP);
    check("len0_count", bus.instr_count, exp_cnt);
    @(negedge clk);
    check("len0_done_once", done_cnt, b + 1);
    write(0, 9'b010_010_001, 1'b0);
    bus.loop_en = 1'b1;
    bus.prog_len = 5'd1;
    for (int i = 0; i < 11; i++) q.push_back(exp_t'{mem_m[0], 4'd0});
    exp_cnt += 16'd11;
    b = done_cnt;
    pulse(1'b1);
    write(5, ~mem_m[5], 1'b1);
    n = 0;
    while (bus.instr_count != exp_cnt - 16'd1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("loop_wait", n < 200, 1'b1);
    @(posedge clk);
    #1 bus.halt = 1'b1;
    @(posedge clk);
    #1 bus.halt = 1'b0;
    wait_idle("halt_wait");
    check("halt_count", bus.instr_count, exp_cnt);
    check("halt_no_done", done_cnt, b);
    check("halt_din", bus.din, NOP);
    check("halt_sb_empty", q.size(), 0);
    bus.loop_en = 1'b0;
    write(5, 9'($urandom), 1'b0);
    b = int'(exp_cnt);
    bus.prog_len = 5'd16;
    for (int a = 0; a < 16; a++) q.push_back(exp_t'{mem_m[a], 4'((a + 1) % 16)});
    pulse(1'b1);
    n = 0;
    while (int'(bus.instr_count) != b + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.tick != 4'b0100 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_wait", n < 8, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_din", bus.din, NOP);
    check("rst_mid_pc", bus.pc, 0);
    check("rst_mid_count", bus.instr_count, 0);
    check("rst_mid_busy", bus.busy, 1'b0);
    q.delete();
    exp_cnt = 16'd0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_prog(16);
    for (int it = 0; it < 5; it++) begin
      for (int a = 0; a < 16; a++) if ($urandom_range(0, 1) == 1) write(a, 9'($urandom), 1'b0);
      run_prog(it == 0 ? 16 + int'($urandom_range(1, 15)) : int'($urandom_range(1, 16)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
